// File: rtl/alu_seq_pkg.sv
// Shared command encodings for the sequential ALU, plus single-cycle/iterative classification.
package alu_seq_pkg;

  localparam int unsigned CMD_W = 5;

  typedef enum logic [CMD_W-1:0] {
    CMD_ADD    = 5'd0,
    CMD_SUB    = 5'd1,
    CMD_AND    = 5'd2,
    CMD_OR     = 5'd3,
    CMD_XOR    = 5'd4,
    CMD_SLL    = 5'd5,
    CMD_SRL    = 5'd6,
    CMD_SRA    = 5'd7,
    CMD_EQ     = 5'd8,
    CMD_NE     = 5'd9,
    CMD_LT     = 5'd10,
    CMD_LTU    = 5'd11,
    CMD_GE     = 5'd12,
    CMD_GEU    = 5'd13,
    CMD_MUL    = 5'd16,
    CMD_MULH   = 5'd17,
    CMD_MULHSU = 5'd18,
    CMD_MULHU  = 5'd19,
    CMD_DIV    = 5'd20,
    CMD_DIVU   = 5'd21,
    CMD_REM    = 5'd22,
    CMD_REMU   = 5'd23
  } command_t;

  // Iterative ops occupy the contiguous block 16..23 (top bits 2'b10).
  function automatic logic is_iter(input command_t c);
    logic [CMD_W-1:0] v;
    v = c;
    return v[CMD_W-1 -: 2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_seq_muldiv_iter.sv
// Iterative multiply/divide: shift-add multiply, restoring divide, XLEN steps after a start pulse.
// Result and done are combinational on the final step so the caller can capture on that edge.
module muldiv_iter
  import alu_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic            abort_i,
  input  command_t        cmd_i,
  input  logic [XLEN-1:0] lhs_i,
  input  logic [XLEN-1:0] rhs_i,
  output logic            done_c,
  output logic [XLEN-1:0] result_c
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  command_t          cmd_q;
  logic              neg_q;
  logic [XLEN-1:0]   hi_q, lo_q, opb_q;

  logic              a_sgn, b_sgn, neg_d, start_mul;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_q;
  logic [XLEN:0]     sum, shifted, diff;
  logic [XLEN-1:0]   hi_d, lo_d;
  logic [2*XLEN-1:0] prod, prod_s;

  // Operand sign pre-correction at start.
  always_comb begin
    a_sgn     = lhs_i[XLEN-1] && (cmd_i inside {CMD_MULH, CMD_MULHSU, CMD_DIV, CMD_REM});
    b_sgn     = rhs_i[XLEN-1] && (cmd_i inside {CMD_MULH, CMD_DIV, CMD_REM});
    a_mag     = a_sgn ? -lhs_i : lhs_i;
    b_mag     = b_sgn ? -rhs_i : rhs_i;
    start_mul = !(cmd_i inside {CMD_DIV, CMD_DIVU, CMD_REM, CMD_REMU});
    case (cmd_i)
      CMD_DIV, CMD_DIVU: neg_d = (a_sgn ^ b_sgn) && (rhs_i != '0);
      CMD_REM, CMD_REMU: neg_d = a_sgn;
      default:           neg_d = a_sgn ^ b_sgn;
    endcase
  end

  // One iteration step, plus sign post-correction of the step's outcome.
  always_comb begin
    div_q   = cmd_q inside {CMD_DIV, CMD_DIVU, CMD_REM, CMD_REMU};
    sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opb_q : '0)};
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, opb_q};
    if (div_q) begin
      hi_d = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], ~diff[XLEN]};
    end else begin
      hi_d = sum[XLEN:1];
      lo_d = {sum[0], lo_q[XLEN-1:1]};
    end
    prod   = {hi_d, lo_d};
    prod_s = neg_q ? -prod : prod;
    case (cmd_q)
      CMD_MUL:                         result_c = prod_s[XLEN-1:0];
      CMD_MULH, CMD_MULHSU, CMD_MULHU: result_c = prod_s[2*XLEN-1:XLEN];
      CMD_DIV, CMD_DIVU:               result_c = neg_q ? -lo_d : lo_d;
      CMD_REM, CMD_REMU:               result_c = neg_q ? -hi_d : hi_d;
      default:                         result_c = '0;
    endcase
    done_c = busy_q && (cnt_q == CNT_W'(XLEN - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      cmd_q  <= CMD_ADD;
      neg_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      opb_q  <= '0;
    end else if (abort_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      cmd_q  <= cmd_i;
      neg_q  <= neg_d;
      hi_q   <= '0;
      lo_q   <= start_mul ? b_mag : a_mag;
      opb_q  <= start_mul ? a_mag : b_mag;
    end else if (busy_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done_c) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops complete on accept, mul/div run XLEN cycles in muldiv_iter.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  command_t        command,
  input  logic [XLEN-1:0] lhs,
  input  logic [XLEN-1:0] rhs,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             state_q;
  logic               accept, md_start, md_done;
  logic [XLEN-1:0]    alu_res, md_res;
  logic [SHAMT_W-1:0] shamt;

  assign in_ready  = !flush && ((state_q == S_IDLE) || (state_q == S_DONE && out_ready));
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid && in_ready;
  assign md_start  = accept && is_iter(command);
  assign shamt     = rhs[SHAMT_W-1:0];

  // Single-cycle datapath; undefined encodings yield zero.
  always_comb begin
    alu_res = '0;
    case (command)
      CMD_ADD: alu_res = lhs + rhs;
      CMD_SUB: alu_res = lhs - rhs;
      CMD_AND: alu_res = lhs & rhs;
      CMD_OR:  alu_res = lhs | rhs;
      CMD_XOR: alu_res = lhs ^ rhs;
      CMD_SLL: alu_res = lhs << shamt;
      CMD_SRL: alu_res = lhs >> shamt;
      CMD_SRA: alu_res = XLEN'($signed(lhs) >>> shamt);
      CMD_EQ:  alu_res = XLEN'(lhs == rhs);
      CMD_NE:  alu_res = XLEN'(lhs != rhs);
      CMD_LT:  alu_res = XLEN'($signed(lhs) < $signed(rhs));
      CMD_LTU: alu_res = XLEN'(lhs < rhs);
      CMD_GE:  alu_res = XLEN'($signed(lhs) >= $signed(rhs));
      CMD_GEU: alu_res = XLEN'(lhs >= rhs);
      default: alu_res = '0;
    endcase
  end

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (md_start),
    .abort_i  (flush),
    .cmd_i    (command),
    .lhs_i    (lhs),
    .rhs_i    (rhs),
    .done_c   (md_done),
    .result_c (md_res)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      res     <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
    end else if (accept) begin
      if (is_iter(command)) begin
        state_q <= S_BUSY;
      end else begin
        state_q <= S_DONE;
        res     <= alu_res;
      end
    end else if (state_q == S_DONE && out_ready) begin
      state_q <= S_IDLE;
    end else if (state_q == S_BUSY && md_done) begin
      state_q <= S_DONE;
      res     <= md_res;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed XLEN=32 cases, then XLEN=8 random traffic against an arithmetic model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk, reset_n;

  logic        iv32, ir32, fl32, ov32, or32;
  command_t    cmd32;
  logic [31:0] lhs32, rhs32, res32;

  logic        iv8, ir8, fl8, ov8, or8;
  command_t    cmd8;
  logic [7:0]  lhs8, rhs8, res8;

  int errors = 0;
  int checks = 0;

  alu_seq #(.XLEN(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv32), .in_ready(ir32), .command(cmd32),
    .lhs(lhs32), .rhs(rhs32), .flush(fl32), .out_valid(ov32), .out_ready(or32), .res(res32)
  );

  alu_seq #(.XLEN(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8), .command(cmd8),
    .lhs(lhs8), .rhs(rhs8), .flush(fl8), .out_valid(ov8), .out_ready(or8), .res(res8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference results from the arithmetic definitions, for widths up to 32.
  function automatic logic [63:0] model(input logic [4:0] c, input logic [63:0] a_in,
                                        input logic [63:0] b_in, input int w);
    logic [63:0] mask, a, b;
    longint sa, sb, mn;
    int sh;
    mask = (64'd1 << w) - 64'd1;
    a  = a_in & mask;
    b  = b_in & mask;
    sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    mn = -(longint'(1) << (w - 1));
    sh = int'(b) & (w - 1);
    case (c)
      5'd0:  return (a + b) & mask;
      5'd1:  return (a - b) & mask;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return (a << sh) & mask;
      5'd6:  return a >> sh;
      5'd7:  return 64'(sa >>> sh) & mask;
      5'd8:  return 64'(a == b);
      5'd9:  return 64'(a != b);
      5'd10: return 64'(sa < sb);
      5'd11: return 64'(a < b);
      5'd12: return 64'(sa >= sb);
      5'd13: return 64'(a >= b);
      5'd16: return 64'(sa * sb) & mask;
      5'd17: return 64'((sa * sb) >>> w) & mask;
      5'd18: return 64'((sa * longint'(b)) >>> w) & mask;
      5'd19: return ((a * b) >> w) & mask;
      5'd20: return (b == 0) ? mask : (sa == mn && sb == -1) ? a : 64'(sa / sb) & mask;
      5'd21: return (b == 0) ? mask : a / b;
      5'd22: return (b == 0) ? a : (sa == mn && sb == -1) ? 64'd0 : 64'(sa % sb) & mask;
      5'd23: return (b == 0) ? a : a % b;
      default: return 64'd0;
    endcase
  endfunction

  // One 32-bit transaction with out_ready high; lat counts edges from accept to out_valid.
  task automatic op32(input string tag, input logic [4:0] c, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    cmd32 = command_t'(c); lhs32 = a; rhs32 = b; iv32 = 1'b1; or32 = 1'b1;
    #1;
    chk({tag, "_ready"}, 64'(ir32), 64'd1);
    tick();
    iv32 = 1'b0; lhs32 = $urandom; rhs32 = $urandom; cmd32 = CMD_SUB;
    n = 1;
    while (!ov32 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_res"}, 64'(res32), 64'(exp));
    tick();
  endtask

  initial begin
    int n, cyc, ready_cyc;
    logic have, exp_rdy;
    logic [7:0] exp8;
    logic [4:0] c;

    reset_n = 1'b0;
    iv32 = 1'b0; fl32 = 1'b0; or32 = 1'b0; cmd32 = CMD_ADD; lhs32 = '0; rhs32 = '0;
    iv8  = 1'b0; fl8  = 1'b0; or8  = 1'b0; cmd8  = CMD_ADD; lhs8  = '0; rhs8  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov32", 64'(ov32), 64'd0);
    chk("rst_res32", 64'(res32), 64'd0);
    chk("rst_ir32", 64'(ir32), 64'd1);
    chk("rst_ov8", 64'(ov8), 64'd0);
    reset_n = 1'b1;
    tick();

    op32("add_wrap", 5'd0,  32'hFFFF_FFFF, 32'h1,         32'h0,         1);
    op32("sra31",    5'd7,  32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1);
    op32("sltu",     5'd11, 32'h1,         32'hFFFF_FFFF, 32'h1,         1);
    op32("undef14",  5'd14, 32'h1234,      32'h5678,      32'h0,         1);
    op32("undef31",  5'd31, 32'hFFFF,      32'h1,         32'h0,         1);
    op32("mulh",     5'd17, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    op32("mulhu",    5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    op32("mul",      5'd16, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 33);
    op32("div_ovf",  5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    op32("rem_ovf",  5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         33);
    op32("divu_z",   5'd21, 32'd7,         32'd0,         32'hFFFF_FFFF, 33);
    op32("remu_z",   5'd23, 32'd7,         32'd0,         32'd7,         33);
    op32("div_neg",  5'd20, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    op32("rem_neg",  5'd22, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    op32("div_z_s",  5'd20, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 33);
    op32("rem_z_s",  5'd22, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 33);

    // Held result under back-pressure, then retire and accept on the same edge.
    cmd32 = CMD_MUL; lhs32 = 32'd3; rhs32 = 32'd5; iv32 = 1'b1; or32 = 1'b0;
    tick();
    iv32 = 1'b0;
    n = 1;
    while (!ov32 && n < 100) begin
      tick();
      n++;
    end
    chk("hold_lat", 64'(n), 64'd33);
    cmd32 = CMD_XOR; lhs32 = 32'hF0; rhs32 = 32'hFF; iv32 = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_res", 64'(res32), 64'd15);
      chk("hold_ir", 64'(ir32), 64'd0);
      chk("hold_ov", 64'(ov32), 64'd1);
      tick();
    end
    or32 = 1'b1;
    #1;
    chk("b2b_ir", 64'(ir32), 64'd1);
    tick();
    iv32 = 1'b0;
    chk("b2b_ov", 64'(ov32), 64'd1);
    chk("b2b_res", 64'(res32), 64'h0F);
    tick();
    chk("b2b_idle", 64'(ov32), 64'd0);

    // Flush mid-BUSY.
    cmd32 = CMD_DIVU; lhs32 = 32'd100; rhs32 = 32'd7; iv32 = 1'b1; or32 = 1'b1;
    tick();
    iv32 = 1'b0;
    repeat (5) tick();
    fl32 = 1'b1; iv32 = 1'b1;
    #1;
    chk("flush_ir", 64'(ir32), 64'd0);
    tick();
    fl32 = 1'b0; iv32 = 1'b0;
    #1;
    chk("flush_ov", 64'(ov32), 64'd0);
    chk("flush_idle_ir", 64'(ir32), 64'd1);
    n = 0;
    repeat (40) begin
      tick();
      if (ov32) n++;
    end
    chk("flush_no_ov", 64'(n), 64'd0);

    // Reset pulse mid-BUSY.
    op32("xor_pre", 5'd4, 32'hF0, 32'hFF, 32'h0F, 1);
    cmd32 = CMD_MULHU; lhs32 = 32'hFFFF; rhs32 = 32'hFFFF; iv32 = 1'b1;
    tick();
    iv32 = 1'b0;
    repeat (10) tick();
    chk("rbusy_ov", 64'(ov32), 64'd0);
    reset_n = 1'b0;
    #1;
    chk("rbusy_rst_ov", 64'(ov32), 64'd0);
    chk("rbusy_rst_res", 64'(res32), 64'd0);
    #3;
    reset_n = 1'b1;
    #1;
    chk("rbusy_rel_ir", 64'(ir32), 64'd1);
    n = 0;
    repeat (40) begin
      tick();
      if (ov32) n++;
    end
    chk("rbusy_no_ov", 64'(n), 64'd0);

    // XLEN=8 random traffic with back-pressure; one transaction can be outstanding.
    have = 1'b0; cyc = 0; ready_cyc = 0; exp8 = '0;
    for (int k = 0; k < 1500; k++) begin
      if (have && cyc >= ready_cyc) begin
        chk("r_ov", 64'(ov8), 64'd1);
        chk("r_res", 64'(res8), 64'(exp8));
      end else begin
        chk("r_ov_lo", 64'(ov8), 64'd0);
      end
      c    = 5'($urandom_range(0, 31));
      iv8  = ($urandom_range(0, 3) != 0);
      cmd8 = command_t'(c);
      lhs8 = 8'($urandom);
      rhs8 = 8'($urandom);
      if ($urandom_range(0, 7) == 0) lhs8 = 8'h80;
      if ($urandom_range(0, 7) == 0) rhs8 = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      or8  = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = !have || (cyc >= ready_cyc && or8);
      chk("r_ir", 64'(ir8), 64'(exp_rdy));
      if (have && cyc >= ready_cyc && or8) have = 1'b0;
      if (iv8 && exp_rdy) begin
        have      = 1'b1;
        exp8      = 8'(model(c, 64'(lhs8), 64'(rhs8), 8));
        ready_cyc = cyc + ((c >= 5'd16 && c <= 5'd23) ? 9 : 1);
      end
      tick();
      cyc++;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
